// File: rtl/kl8e_keyboard.sv
// kl8e_keyboard: PDP-8 console keyboard receiver (KL8E, IOT device 03).
// Deserialises 8N1 async serial from rx into a receive buffer and raises
// kbd_flag. It also decodes the IOT 603x instructions for AC transfer, skip
// and flag control.
//
// Ports:
//   SYSCLK            system clock, all state on the rising edge
//   RESET             asynchronous active-high reset
//   rx                serial input, idle high, asynchronous to SYSCLK
//   iot/iot_dev/iot_op  IOT strobe, device field IR[8:3], op bits IR[2:0]
//   ac_in             current AC
//   ac_out/ac_we      value to load into AC, and its load enable
//   skip              skip the next instruction
//   kbd_flag          byte available
//   frame_err         sticky: stop bit sampled low
//   overrun           sticky: byte completed while the flag was still set
//   irq               interrupt request
//
// Optional feature macro: KL8E_INT_EN. When it is defined, the block has an
// interrupt-enable register written by KIE, and irq = kbd_flag & ie
// (registered). When it is undefined, irq is tied to 0.
module kl8e_keyboard #(
  parameter int unsigned CLKS_PER_BIT = 109,
  parameter logic [5:0]  DEVICE       = 6'o03
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        rx,
  input  logic        iot,
  input  logic [5:0]  iot_dev,
  input  logic [2:0]  iot_op,
  input  logic [11:0] ac_in,
  output logic [11:0] ac_out,
  output logic        ac_we,
  output logic        skip,
  output logic        kbd_flag,
  output logic        frame_err,
  output logic        overrun,
  output logic        irq
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            rx_meta_q, rx_sync_q;
  logic            flag_q, flag_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            sel, flag_clr;

  // IOT decode: purely combinational from the op bits and current state.
  assign sel = iot && (iot_dev == DEVICE);

  always_comb begin
    ac_out   = 12'd0;
    ac_we    = 1'b0;
    skip     = 1'b0;
    flag_clr = 1'b0;
    if (sel) begin
      unique case (iot_op)
        3'd0: flag_clr = 1'b1;
        3'd1: skip = flag_q;
        3'd2: begin
          ac_we    = 1'b1;
          flag_clr = 1'b1;
        end
        3'd3: begin
          skip     = flag_q;
          flag_clr = 1'b1;
        end
        3'd4: begin
          ac_we  = 1'b1;
          ac_out = ac_in | {4'b0, data_q};
        end
        3'd5: ;  // KIE: handled by the interrupt-enable logic when present
        3'd6: begin
          ac_we    = 1'b1;
          ac_out   = {4'b0, data_q};
          flag_clr = 1'b1;
        end
        3'd7: begin
          skip     = flag_q;
          ac_we    = 1'b1;
          ac_out   = {4'b0, data_q};
          flag_clr = 1'b1;
        end
      endcase
    end
  end

  // Receive FSM; a completing byte overrides a same-cycle flag clear.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    flag_d      = flag_clr ? 1'b0 : flag_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_sync_q) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!rx_sync_q) begin
          state_d   = StData;
          cnt_d     = BitLoad;
          bit_idx_d = 3'd0;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          cnt_d     = BitLoad;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rx_sync_q) begin
          data_d  = shreg_q;
          flag_d  = 1'b1;
          if (flag_q && !flag_clr) overrun_d = 1'b1;
          state_d = StIdle;
        end else begin
          frame_err_d = 1'b1;
          state_d     = StBreak;
        end
      end
      StBreak: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'd0;
      data_q      <= 8'd0;
      flag_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      flag_q      <= flag_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign kbd_flag  = flag_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef KL8E_INT_EN
  logic ie_q, ie_d, irq_q, irq_d;

  always_comb begin
    ie_d  = ie_q;
    if (sel && (iot_op == 3'd5)) ie_d = ac_in[0];
    irq_d = flag_q & ie_q;
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      ie_q  <= 1'b1;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
